hazard_control_unit: RTL and testbench

- Pipeline sequencer for the 5-stage RV32 core; owns all stall, bubble and flush controls around the EX-stage forwarding datapath.
- Detects load-use hazards in ID and applies taken-branch flushes resolved in EX.
- Holds the pipeline for the full occupancy of multi-cycle MUL/DIV ops in EX, and freezes everything on a memory wait.
- Keeps a stall-cycle performance counter.

---
 rtl/hazard_control_unit.sv | 129 ++++++++++++
 tb/tb_hazard_control_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, MUL/DIV holds, memory-wait freeze.
// Latency: control outputs are combinational from state/mdcnt/inputs; MD_Busy and StallCount are registered.
// Backpressure: MEM_Stall freezes the whole pipeline and the sequencer state; nothing is dropped.
module hazard_control_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_RegisterRs1,
    input  logic [4:0]       ID_RegisterRs2,
    input  logic             ID_UsesRs1,
    input  logic             ID_UsesRs2,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_MulDiv,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Stall,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Bubble,
    output logic             MD_Start,
    output logic             MD_Busy,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // The trigger cycle is spent in RUN and the release cycle at mdcnt==0,
    // so the countdown starts two short of the full EX occupancy.
    localparam logic [3:0]       MD_INIT = 4'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    state_t     next_state;
    logic [3:0] mdcnt;
    logic [3:0] next_mdcnt;
    logic       load_use;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                      ((ID_UsesRs1 && (ID_RegisterRs1 == ID_EX_RegisterRd)) ||
                       (ID_UsesRs2 && (ID_RegisterRs2 == ID_EX_RegisterRd)));

    // Priority-resolved pipeline controls and sequencer next state
    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        ID_EX_Bubble  = 1'b0;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Bubble = 1'b0;
        MD_Start      = 1'b0;
        next_state    = state;
        next_mdcnt    = mdcnt;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (MEM_Stall) begin
                        // Full freeze; a branch in EX is still there next cycle
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Write = 1'b0;
                    end else if (EX_BranchTaken) begin
                        // The ID instruction is discarded, so load-use is moot
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (ID_EX_MulDiv) begin
                        MD_Start      = 1'b1;
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                        next_state    = MD_BUSY;
                        next_mdcnt    = MD_INIT;
                    end else if (load_use) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (MEM_Stall) begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                    end else if (mdcnt != 4'd0) begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                        next_mdcnt    = mdcnt - 4'd1;
                    end else begin
                        // Release: result enters EX/MEM, ID/EX advances normally
                        next_state = RUN;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    // Sequencer state, busy flag and stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            mdcnt      <= 4'd0;
            MD_Busy    <= 1'b0;
            StallCount <= '0;
        end else begin
            state   <= next_state;
            mdcnt   <= next_mdcnt;
            MD_Busy <= (next_state == MD_BUSY);
            if (!PCWrite) begin
                StallCount <= StallCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a per-cycle reference model.
// Latency: model compares every negedge; literal checks pin specific scenarios.
// Backpressure: MEM_Stall scenarios exercised in both RUN and MUL/DIV occupancy.
module tb_hazard_control_unit;

    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1, rs2, rd;
    logic             uses1, uses2, memread, muldiv, branch, memstall;
    logic             pcw, ifidw, idexw, idexbub, ifidfl, idexfl, exmembub, mdstart, mdbusy;
    logic [CNT_W-1:0] stallcnt;

    int checks = 0;
    int fails  = 0;

    hazard_control_unit #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_RegisterRs1(rs1), .ID_RegisterRs2(rs2),
        .ID_UsesRs1(uses1), .ID_UsesRs2(uses2),
        .ID_EX_RegisterRd(rd), .ID_EX_MemRead(memread), .ID_EX_MulDiv(muldiv),
        .EX_BranchTaken(branch), .MEM_Stall(memstall),
        .PCWrite(pcw), .IF_ID_Write(ifidw), .ID_EX_Write(idexw),
        .ID_EX_Bubble(idexbub), .IF_ID_Flush(ifidfl), .ID_EX_Flush(idexfl),
        .EX_MEM_Bubble(exmembub), .MD_Start(mdstart), .MD_Busy(mdbusy),
        .StallCount(stallcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: cycles of MUL/DIV occupancy still owed after this one,
    // and the running number of stalled cycles.
    int               md_left = 0;
    logic [CNT_W-1:0] m_cnt   = '0;

    always @(negedge clk) begin
        logic e_pcw, e_ifw, e_idw, e_bub, e_iff, e_idf, e_emb, e_st, ld;
        int nxt_left;
        e_pcw = 1; e_ifw = 1; e_idw = 1; e_bub = 0; e_iff = 0; e_idf = 0; e_emb = 0; e_st = 0;
        nxt_left = md_left;
        ld = memread && rd != 0 && ((uses1 && rs1 == rd) || (uses2 && rs2 == rd));
        if (rst) begin
            nxt_left = 0;
        end else if (md_left == 0) begin
            if (memstall) begin
                e_pcw = 0; e_ifw = 0; e_idw = 0;
            end else if (branch) begin
                e_iff = 1; e_idf = 1;
            end else if (muldiv) begin
                e_st = 1; e_pcw = 0; e_ifw = 0; e_idw = 0; e_emb = 1;
                nxt_left = MD_LATENCY - 1;
            end else if (ld) begin
                e_pcw = 0; e_ifw = 0; e_bub = 1;
            end
        end else if (memstall) begin
            e_pcw = 0; e_ifw = 0; e_idw = 0; e_emb = 1;
        end else if (md_left > 1) begin
            e_pcw = 0; e_ifw = 0; e_idw = 0; e_emb = 1;
            nxt_left = md_left - 1;
        end else begin
            nxt_left = 0;
        end
        check("model PCWrite", pcw, e_pcw);
        check("model IF_ID_Write", ifidw, e_ifw);
        check("model ID_EX_Write", idexw, e_idw);
        check("model ID_EX_Bubble", idexbub, e_bub);
        check("model IF_ID_Flush", ifidfl, e_iff);
        check("model ID_EX_Flush", idexfl, e_idf);
        check("model EX_MEM_Bubble", exmembub, e_emb);
        check("model MD_Start", mdstart, e_st);
        check("model MD_Busy", mdbusy, md_left > 0);
        check("model StallCount", stallcnt, m_cnt);
        if (rst) m_cnt = '0;
        else if (!e_pcw) m_cnt = m_cnt + 1;
        md_left = nxt_left;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; uses1 = 0; uses2 = 0;
        memread = 0; muldiv = 0; branch = 0; memstall = 0;
    endtask

    initial begin
        int n_pc0, n_st, n_emb, n_busy, n_rel;
        logic [CNT_W-1:0] base;
        idle();
        rst = 1;
        muldiv = 1;
        #1;
        // Reset forces defaults even with a MUL/DIV presented
        check("reset MD_Start", mdstart, 0);
        check("reset PCWrite", pcw, 1);
        tick(); tick();
        rst = 0; muldiv = 0;
        #1;
        check("post-reset StallCount", stallcnt, 0);
        check("post-reset MD_Busy", mdbusy, 0);

        // Load-use: lw x5 ; add x6,x5,x7
        memread = 1; rd = 5; rs1 = 5; uses1 = 1; rs2 = 7; uses2 = 1;
        #1;
        check("loaduse PCWrite", pcw, 0);
        check("loaduse IF_ID_Write", ifidw, 0);
        check("loaduse Bubble", idexbub, 1);
        tick();
        memread = 0; rd = 0;
        #1;
        check("loaduse next PCWrite", pcw, 1);
        check("loaduse StallCount", stallcnt, 1);
        tick();

        // x0 destination never stalls
        memread = 1; rd = 0; rs1 = 0; uses1 = 1; uses2 = 0;
        #1;
        check("x0 PCWrite", pcw, 1);
        tick();
        // Matching rs2 that is not read
        rd = 5; rs1 = 3; uses1 = 1; rs2 = 5; uses2 = 0;
        #1;
        check("unused rs2 PCWrite", pcw, 1);
        tick();
        // Same, but rs2 is read
        uses2 = 1;
        #1;
        check("rs2 loaduse Bubble", idexbub, 1);
        tick();
        idle();
        tick();

        // Branch overrides load-use
        branch = 1; memread = 1; rd = 5; rs1 = 5; uses1 = 1;
        #1;
        check("br+lu IF_ID_Flush", ifidfl, 1);
        check("br+lu ID_EX_Flush", idexfl, 1);
        check("br+lu Bubble", idexbub, 0);
        check("br+lu PCWrite", pcw, 1);
        tick();
        idle();

        // MEM_Stall defers a branch flush
        branch = 1; memstall = 1;
        #1;
        check("memstall br Flush", ifidfl, 0);
        check("memstall br PCWrite", pcw, 0);
        tick();
        memstall = 0;
        #1;
        check("deferred br Flush", ifidfl, 1);
        tick();
        idle();
        tick();

        // MUL/DIV occupancy, MD_LATENCY=4
        base = stallcnt;
        n_pc0 = 0; n_st = 0; n_emb = 0; n_busy = 0;
        for (int c = 0; c < 6; c++) begin
            muldiv = (c < MD_LATENCY);
            #1;
            n_pc0 += !pcw; n_st += mdstart; n_emb += exmembub; n_busy += mdbusy;
            if (c == MD_LATENCY - 1) check("md release PCWrite", pcw, 1);
            tick();
        end
        check("md MD_Start cycles", n_st, 1);
        check("md PCWrite=0 cycles", n_pc0, 3);
        check("md EX_MEM_Bubble cycles", n_emb, 3);
        check("md MD_Busy cycles", n_busy, 3);
        check("md StallCount delta", stallcnt - base, 3);
        idle();

        // MEM_Stall for two cycles right after MD_Start
        n_pc0 = 0; n_st = 0; n_rel = 0;
        for (int c = 0; c < 8; c++) begin
            muldiv = (c < 6);
            memstall = (c == 1 || c == 2);
            #1;
            n_pc0 += !pcw; n_st += mdstart; n_rel += (mdbusy && pcw);
            tick();
        end
        check("md+mem PCWrite=0 cycles", n_pc0, 5);
        check("md+mem MD_Start cycles", n_st, 1);
        check("md+mem release cycles", n_rel, 1);
        idle();

        // Back-to-back MUL/DIV re-triggers right after release
        muldiv = 1;
        for (int c = 0; c < MD_LATENCY; c++) tick();
        #1;
        check("b2b MD_Start", mdstart, 1);
        check("b2b MD_Busy", mdbusy, 0);
        tick();
        // Reset mid-MD_BUSY
        check("pre-reset MD_Busy", mdbusy, 1);
        rst = 1;
        tick();
        rst = 0; muldiv = 0;
        #1;
        check("rst-mid MD_Busy", mdbusy, 0);
        check("rst-mid StallCount", stallcnt, 0);
        check("rst-mid PCWrite", pcw, 1);
        check("rst-mid IF_ID_Write", ifidw, 1);
        check("rst-mid ID_EX_Write", idexw, 1);
        tick(); tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
